// File: rtl/miriscv_mem_arbiter.sv
// miriscv_mem_arbiter
// Shares one external memory port between the instruction-fetch and data
// interfaces of the core. Each requester has a one-entry holding register;
// granted transactions are tracked in an owner FIFO so the in-order memory
// responses can be steered back to the requester that issued them.
//
// Issue FSM
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | no request on the bus; arbitrate pending/incoming requests
//   S_REQ  | mem_req_o asserted, mem_* held stable until mem_gnt_i
module miriscv_mem_arbiter #(
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ARB_MODE        = 0
) (
    input  logic              clk_i,
    input  logic              arstn_i,

    input  logic              instr_req_i,
    input  logic [XLEN-1:0]   instr_addr_i,
    output logic              instr_rvalid_o,
    output logic [XLEN-1:0]   instr_rdata_o,

    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [XLEN/8-1:0] data_be_i,
    input  logic [XLEN-1:0]   data_addr_i,
    input  logic [XLEN-1:0]   data_wdata_i,
    output logic              data_rvalid_o,
    output logic [XLEN-1:0]   data_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    localparam int BE_W  = XLEN / 8;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t state_q, state_d;

    // holding registers and per-port status
    logic              instr_pend_q, instr_busy_q;
    logic [XLEN-1:0]   instr_addr_q;
    logic              data_pend_q, data_busy_q;
    logic              data_we_q;
    logic [BE_W-1:0]   data_be_q;
    logic [XLEN-1:0]   data_addr_q;
    logic [XLEN-1:0]   data_wdata_q;

    // owner FIFO: 0 = instr, 1 = data
    logic              owner_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              win_q;      // owner of the transaction currently on the bus
    logic              rr_ptr_q;   // round-robin preference: 0 = instr, 1 = data

    logic              instr_cap, data_cap;
    logic              instr_avail, data_avail;
    logic              fifo_pop, fifo_push, fifo_full, fifo_head;
    logic              can_issue, gnt_fire, issue, pick_data;

    logic              data_we_sel;
    logic [BE_W-1:0]   data_be_sel;
    logic [XLEN-1:0]   data_addr_sel, data_wdata_sel, instr_addr_sel;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) return '0;
        else                                  return p + 1'b1;
    endfunction

    // A busy port (pending or awaiting its response) ignores further strobes.
    assign instr_cap   = instr_req_i & ~instr_busy_q;
    assign data_cap    = data_req_i  & ~data_busy_q;

    // Incoming strobes are visible to the arbiter in the same cycle so the
    // request can reach the bus the cycle after the strobe.
    assign instr_avail = instr_pend_q | instr_cap;
    assign data_avail  = data_pend_q  | data_cap;

    assign instr_addr_sel = instr_pend_q ? instr_addr_q : instr_addr_i;
    assign data_we_sel    = data_pend_q  ? data_we_q    : data_we_i;
    assign data_be_sel    = data_pend_q  ? data_be_q    : data_be_i;
    assign data_addr_sel  = data_pend_q  ? data_addr_q  : data_addr_i;
    assign data_wdata_sel = data_pend_q  ? data_wdata_q : data_wdata_i;

    assign fifo_head = owner_q[rd_ptr_q];
    assign fifo_pop  = mem_rvalid_i & (cnt_q != '0);
    assign fifo_full = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign gnt_fire  = (state_q == S_REQ) & mem_gnt_i;
    assign fifo_push = gnt_fire;
    // A slot freed by this cycle's response may be reused immediately.
    assign can_issue = ~fifo_full | fifo_pop;

    // Arbitration between the two requesters.
    always_comb begin
        pick_data = 1'b0;
        if (data_avail && !instr_avail) begin
            pick_data = 1'b1;
        end else if (data_avail && instr_avail) begin
            pick_data = (ARB_MODE == 0) ? 1'b1 : rr_ptr_q;
        end
    end

    // Issue FSM next-state logic.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((instr_avail || data_avail) && can_issue) begin
                    issue   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Registered memory-side request outputs and winner/round-robin tracking.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            win_q       <= 1'b0;
            rr_ptr_q    <= 1'b0;
        end else begin
            if (issue) begin
                mem_req_o   <= 1'b1;
                win_q       <= pick_data;
                mem_we_o    <= pick_data ? data_we_sel    : 1'b0;
                mem_be_o    <= pick_data ? data_be_sel    : {BE_W{1'b1}};
                mem_addr_o  <= pick_data ? data_addr_sel  : instr_addr_sel;
                mem_wdata_o <= pick_data ? data_wdata_sel : '0;
            end else if (gnt_fire) begin
                mem_req_o   <= 1'b0;
            end
            if (gnt_fire) rr_ptr_q <= ~win_q;
        end
    end

    // Holding registers, pending flags and in-flight (busy) flags.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            instr_pend_q <= 1'b0;
            instr_busy_q <= 1'b0;
            instr_addr_q <= '0;
            data_pend_q  <= 1'b0;
            data_busy_q  <= 1'b0;
            data_we_q    <= 1'b0;
            data_be_q    <= '0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
        end else begin
            if (instr_cap) begin
                instr_pend_q <= 1'b1;
                instr_busy_q <= 1'b1;
                instr_addr_q <= instr_addr_i;
            end
            if (data_cap) begin
                data_pend_q  <= 1'b1;
                data_busy_q  <= 1'b1;
                data_we_q    <= data_we_i;
                data_be_q    <= data_be_i;
                data_addr_q  <= data_addr_i;
                data_wdata_q <= data_wdata_i;
            end
            if (gnt_fire && !win_q) instr_pend_q <= 1'b0;
            if (gnt_fire &&  win_q) data_pend_q  <= 1'b0;
            if (fifo_pop && !fifo_head) instr_busy_q <= 1'b0;
            if (fifo_pop &&  fifo_head) data_busy_q  <= 1'b0;
        end
    end

    // Owner FIFO pointers, occupancy and storage.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) owner_q[i] <= 1'b0;
        end else begin
            if (fifo_push) begin
                owner_q[wr_ptr_q] <= win_q;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (fifo_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({fifo_push, fifo_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Response steering to the requester at the FIFO head.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            instr_rvalid_o <= 1'b0;
            instr_rdata_o  <= '0;
            data_rvalid_o  <= 1'b0;
            data_rdata_o   <= '0;
        end else begin
            instr_rvalid_o <= fifo_pop & ~fifo_head;
            data_rvalid_o  <= fifo_pop &  fifo_head;
            if (fifo_pop && !fifo_head) instr_rdata_o <= mem_rdata_i;
            if (fifo_pop &&  fifo_head) data_rdata_o  <= mem_rdata_i;
        end
    end

`ifndef SYNTHESIS
    // Protocol checks on the requester and memory sides.
    always @(posedge clk_i) begin
        if (arstn_i) begin
            assert (!(instr_req_i && instr_busy_q))
                else $error("miriscv_mem_arbiter: instr strobe while port busy");
            assert (!(data_req_i && data_busy_q))
                else $error("miriscv_mem_arbiter: data strobe while port busy");
            assert (!(mem_rvalid_i && (cnt_q == '0)))
                else $error("miriscv_mem_arbiter: mem_rvalid_i with no outstanding request");
        end
    end
`endif

endmodule
